// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter between the fetcher and the LSQ.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LSQ-first with a bounded LSQ streak, and a fetch
// response drop after a pipeline flush.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned width        = 32,
    parameter int unsigned d_streak_max = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,

    input  logic                 i_mem_read,
    input  logic [width-1:0]     i_mem_address,
    output logic                 i_mem_resp,
    output logic [width-1:0]     i_mem_rdata,

    input  logic                 lsq_mem_read,
    input  logic                 lsq_mem_write,
    input  logic [width/8-1:0]   lsq_mem_byte_enable,
    input  logic [width-1:0]     lsq_mem_address,
    input  logic [width-1:0]     lsq_mem_wdata,
    output logic                 lsq_mem_resp,
    output logic [width-1:0]     lsq_mem_rdata,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width/8-1:0]   mem_byte_enable,
    output logic [width-1:0]     mem_address,
    output logic [width-1:0]     mem_wdata,
    input  logic                 mem_resp,
    input  logic [width-1:0]     mem_rdata,

    output logic                 arb_busy
);

    localparam logic [3:0] STREAK_MAX = 4'(d_streak_max);

    arb_state_t          state_q, state_d;
    arb_owner_t          owner;
    logic                grant_i, grant_d;
    logic                fetch_req, lsq_req, serving;
    logic [3:0]          streak_q;
    logic                drop_q;
    logic                rd_q, wr_q;
    logic [width/8-1:0]  be_q;
    logic [width-1:0]    addr_q, wdata_q;

    always_comb begin
        state_d   = state_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        // A flush cycle never grants fetch, so fetch counts as idle here.
        fetch_req = i_mem_read & ~flush;
        lsq_req   = lsq_mem_read | lsq_mem_write;
        unique case (state_q)
            IDLE: begin
                if (lsq_req && (!fetch_req || streak_q < STREAK_MAX)) begin
                    state_d = SERVE_D;
                    grant_d = 1'b1;
                end else if (fetch_req) begin
                    state_d = SERVE_I;
                    grant_i = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        serving       = (state_q != IDLE);
        owner         = (state_q == SERVE_I) ? OWN_I : OWN_D;
        i_mem_resp    = serving && (owner == OWN_I) && mem_resp && !drop_q && !flush;
        lsq_mem_resp  = serving && (owner == OWN_D) && mem_resp;
        i_mem_rdata   = i_mem_resp   ? mem_rdata : '0;
        lsq_mem_rdata = lsq_mem_resp ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            drop_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                addr_q  <= lsq_mem_address;
                wdata_q <= lsq_mem_wdata;
                be_q    <= lsq_mem_byte_enable;
                wr_q    <= lsq_mem_write;
                rd_q    <= lsq_mem_read & ~lsq_mem_write;
                if (fetch_req)
                    streak_q <= (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                else
                    streak_q <= '0;
            end
            if (grant_i) begin
                addr_q   <= i_mem_address;
                wdata_q  <= '0;
                be_q     <= '1;
                wr_q     <= 1'b0;
                rd_q     <= 1'b1;
                streak_q <= '0;
                drop_q   <= 1'b0;
            end
            if (state_q == SERVE_I && flush) drop_q <= 1'b1;
            // Response completion wins over a same-cycle flush mark.
            if (serving && mem_resp) begin
                rd_q    <= 1'b0;
                wr_q    <= 1'b0;
                be_q    <= '0;
                addr_q  <= '0;
                wdata_q <= '0;
                drop_q  <= 1'b0;
            end
        end
    end

    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign arb_busy        = serving;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all cycles compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned STREAK = 4;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic        i_mem_resp;
    logic [31:0] i_mem_rdata;
    logic        lsq_mem_read, lsq_mem_write;
    logic [3:0]  lsq_mem_byte_enable;
    logic [31:0] lsq_mem_address, lsq_mem_wdata;
    logic        lsq_mem_resp;
    logic [31:0] lsq_mem_rdata;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    mem_port_arbiter #(.width(32), .d_streak_max(STREAK)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .lsq_mem_read(lsq_mem_read), .lsq_mem_write(lsq_mem_write),
        .lsq_mem_byte_enable(lsq_mem_byte_enable), .lsq_mem_address(lsq_mem_address),
        .lsq_mem_wdata(lsq_mem_wdata), .lsq_mem_resp(lsq_mem_resp),
        .lsq_mem_rdata(lsq_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: one outstanding transfer with its owner.
    bit          m_busy, m_fetch, m_drop, m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_streak, m_age;

    bit          auto_mem = 0;
    int          mem_lat  = 1;
    bit          got_i, got_d;
    bit          grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit fw, lw, ir, dr;
        @(negedge clk);
        ir = m_busy && m_fetch && mem_resp && !m_drop && !flush;
        dr = m_busy && !m_fetch && mem_resp;
        chk("busy",   32'(arb_busy),        32'(m_busy));
        chk("m_rd",   32'(mem_read),        32'(m_busy && m_rd));
        chk("m_wr",   32'(mem_write),       32'(m_busy && m_wr));
        chk("m_addr", mem_address,          m_busy ? m_addr : 32'h0);
        chk("m_wd",   mem_wdata,            m_busy ? m_wdata : 32'h0);
        chk("m_be",   32'(mem_byte_enable), 32'(m_busy ? m_be : 4'h0));
        chk("i_resp", 32'(i_mem_resp),      32'(ir));
        chk("d_resp", 32'(lsq_mem_resp),    32'(dr));
        chk("i_rd",   i_mem_rdata,          ir ? mem_rdata : 32'h0);
        chk("d_rd",   lsq_mem_rdata,        dr ? mem_rdata : 32'h0);
        got_i = (i_mem_resp === 1'b1);
        got_d = (lsq_mem_resp === 1'b1);
        if (got_i) grant_log.push_back(1'b1);
        if (got_d) grant_log.push_back(1'b0);

        if (rst) begin
            m_busy = 0; m_drop = 0; m_streak = 0; m_age = 0;
        end else if (m_busy) begin
            m_age++;
            if (m_fetch && flush) m_drop = 1;
            if (mem_resp) begin m_busy = 0; m_drop = 0; end
        end else begin
            fw = i_mem_read && !flush;
            lw = lsq_mem_read || lsq_mem_write;
            if (lw && (!fw || m_streak < STREAK)) begin
                m_busy = 1; m_fetch = 0; m_age = 0;
                m_addr = lsq_mem_address; m_wdata = lsq_mem_wdata; m_be = lsq_mem_byte_enable;
                m_wr = lsq_mem_write; m_rd = !lsq_mem_write;
                m_streak = fw ? ((m_streak + 1 > STREAK) ? STREAK : m_streak + 1) : 0;
            end else if (fw) begin
                m_busy = 1; m_fetch = 1; m_age = 0; m_drop = 0;
                m_addr = i_mem_address; m_wdata = 0; m_be = 4'hF;
                m_wr = 0; m_rd = 1; m_streak = 0;
            end
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_rdata = $urandom;
            if (m_busy) mem_resp = (m_age >= mem_lat);
            else begin
                mem_resp = ($urandom % 4 == 0);
                mem_lat  = $urandom % 4;
            end
        end
    endtask

    task automatic idle_inputs();
        flush = 0; i_mem_read = 0; lsq_mem_read = 0; lsq_mem_write = 0; mem_resp = 0;
    endtask

    initial begin
        bit exp_seq [6];
        rst = 1; idle_inputs();
        i_mem_address = 0; lsq_mem_byte_enable = 0; lsq_mem_address = 0;
        lsq_mem_wdata = 0; mem_rdata = 0;
        m_busy = 0; m_fetch = 0; m_drop = 0; m_rd = 0; m_wr = 0;
        m_addr = 0; m_wdata = 0; m_be = 0; m_streak = 0; m_age = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_busy", 32'(arb_busy), 32'h0);
        chk("rst_rd",   32'(mem_read), 32'h0);

        // Lone fetch, response three cycles after the request.
        i_mem_read = 1; i_mem_address = 32'h60; tick();
        #1; chk("lf_rd", 32'(mem_read), 32'h1); chk("lf_addr", mem_address, 32'h60);
        chk("lf_be", 32'(mem_byte_enable), 32'hF);
        tick(); tick();
        mem_resp = 1; mem_rdata = 32'h13;
        #1; chk("lf_resp", 32'(i_mem_resp), 32'h1); chk("lf_rdata", i_mem_rdata, 32'h13);
        chk("lf_other", lsq_mem_rdata, 32'h0);
        tick();
        idle_inputs(); #1; chk("lf_done", 32'(arb_busy), 32'h0);
        tick();

        // Simultaneous fetch and LSQ write: LSQ first, fetch two cycles after resp.
        i_mem_read = 1; i_mem_address = 32'h64;
        lsq_mem_write = 1; lsq_mem_address = 32'h1000; lsq_mem_wdata = 32'hDEADBEEF;
        lsq_mem_byte_enable = 4'b0011;
        tick();
        #1; chk("sim_wr", 32'(mem_write), 32'h1); chk("sim_rd", 32'(mem_read), 32'h0);
        chk("sim_be", 32'(mem_byte_enable), 32'h3); chk("sim_wd", mem_wdata, 32'hDEADBEEF);
        chk("sim_addr", mem_address, 32'h1000);
        tick();
        mem_resp = 1; #1; chk("sim_dresp", 32'(lsq_mem_resp), 32'h1);
        chk("sim_iresp", 32'(i_mem_resp), 32'h0);
        tick();
        lsq_mem_write = 0; mem_resp = 0;
        #1; chk("sim_gap", 32'(mem_read), 32'h0);
        tick();
        #1; chk("sim_frd", 32'(mem_read), 32'h1); chk("sim_faddr", mem_address, 32'h64);
        tick();
        mem_resp = 1; tick();
        idle_inputs(); tick();

        // Starvation bound with both requesters held.
        rst = 1; tick(); rst = 0;
        grant_log.delete();
        auto_mem = 1; mem_lat = 1; mem_resp = 0;
        i_mem_read = 1; i_mem_address = 32'h300;
        lsq_mem_read = 1; lsq_mem_address = 32'h2000; lsq_mem_byte_enable = 4'hF;
        for (int unsigned k = 0; k < 80 && grant_log.size() < 6; k++) tick();
        exp_seq = '{0, 0, 0, 0, 1, 0};
        chk("starve_cnt", 32'(grant_log.size() >= 6), 32'h1);
        for (int k = 0; k < 6; k++)
            if (k < grant_log.size()) chk($sformatf("starve_%0d", k), 32'(grant_log[k]), 32'(exp_seq[k]));
        auto_mem = 0; idle_inputs();
        for (int unsigned k = 0; k < 20 && m_busy; k++) begin
            mem_resp = 1; tick();
        end
        mem_resp = 0; tick();

        // Flush after the fetch grant drops that response.
        i_mem_read = 1; i_mem_address = 32'h80; tick();
        flush = 1; tick();
        flush = 0; i_mem_read = 0; tick();
        mem_resp = 1; mem_rdata = 32'h5555AAAA;
        #1; chk("fl_drop", 32'(i_mem_resp), 32'h0);
        tick();
        mem_resp = 0; tick();
        i_mem_read = 1; i_mem_address = 32'h200; tick();
        #1; chk("fl_addr", mem_address, 32'h200);
        tick();
        mem_resp = 1; #1; chk("fl_resp", 32'(i_mem_resp), 32'h1);
        tick();
        idle_inputs(); tick();

        // Reset in the middle of an LSQ read.
        lsq_mem_read = 1; lsq_mem_address = 32'h3000; tick();
        tick();
        rst = 1; tick();
        rst = 0; lsq_mem_read = 0; mem_resp = 1;
        #1; chk("rs_rd", 32'(mem_read), 32'h0); chk("rs_busy", 32'(arb_busy), 32'h0);
        chk("rs_dresp", 32'(lsq_mem_resp), 32'h0);
        tick();
        mem_resp = 0; i_mem_read = 1; i_mem_address = 32'h400; tick();
        #1; chk("rs_frd", 32'(mem_read), 32'h1); chk("rs_faddr", mem_address, 32'h400);
        mem_resp = 1; tick();
        idle_inputs(); tick();

        // Read and write together: write wins.
        lsq_mem_read = 1; lsq_mem_write = 1; lsq_mem_address = 32'h40;
        lsq_mem_wdata = 32'hCAFEF00D; lsq_mem_byte_enable = 4'hF; tick();
        #1; chk("rw_wr", 32'(mem_write), 32'h1); chk("rw_rd", 32'(mem_read), 32'h0);
        chk("rw_wd", mem_wdata, 32'hCAFEF00D);
        mem_resp = 1; tick();
        idle_inputs(); tick();

        // Randomized traffic.
        auto_mem = 1;
        for (int unsigned n = 0; n < 2000; n++) begin
            rst = ($urandom % 300 == 0);
            if (got_i || flush || rst) i_mem_read = 0;
            if (got_d || rst) begin lsq_mem_read = 0; lsq_mem_write = 0; end
            flush = ($urandom % 12 == 0);
            if (!i_mem_read && $urandom % 3 == 0) begin
                i_mem_read = 1; i_mem_address = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsq_mem_read && !lsq_mem_write && $urandom % 3 == 0) begin
                case ($urandom % 3)
                    0: lsq_mem_read = 1;
                    1: lsq_mem_write = 1;
                    default: begin lsq_mem_read = 1; lsq_mem_write = 1; end
                endcase
                lsq_mem_address = $urandom; lsq_mem_wdata = $urandom;
                lsq_mem_byte_enable = 4'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
